// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// latched request record and the address range/alignment check.
package riscv_mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BE_W       = 4;
    localparam int ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // One extra bit catches addresses below base as a borrow out of the subtraction.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] base,
                                      input logic [WORD_W:0]   span);
        logic [WORD_W:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr[ALIGN_BITS-1:0] != '0) || off[WORD_W] || (off >= span);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core and the data memory.
interface data_mem_responder_if;
    import riscv_mem_pkg::*;

    logic              Req_valid;
    logic              Req_ready;
    logic              Req_we;
    logic [WORD_W-1:0] Req_addr;
    logic [WORD_W-1:0] Req_wdata;
    logic [BE_W-1:0]   Req_be;
    logic              Resp_valid;
    logic              Resp_ready;
    logic [WORD_W-1:0] Resp_rdata;
    logic              Resp_err;

    modport master (
        output Req_valid, Req_we, Req_addr, Req_wdata, Req_be, Resp_ready,
        input  Req_ready, Resp_valid, Resp_rdata, Resp_err
    );

    modport slave (
        input  Req_valid, Req_we, Req_addr, Req_wdata, Req_be, Resp_ready,
        output Req_ready, Resp_valid, Resp_rdata, Resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Variable-latency data memory for the core's load/store port: one request in
// flight, serviced after WAIT_STATES cycles, answered over a valid/ready response.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus
);

    localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WORD_W:0] SPAN     = 33'(DEPTH_WORDS * 4);
    localparam logic [3:0]      CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rdok_q, rdok_d;
    req_t              req_q, req_d;
    req_t              live, src;
    logic              accept, enter_resp, src_err, ram_en;
    logic [WORD_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] ram_rdata;

    always_comb begin
        live   = {bus.Req_we, bus.Req_addr, bus.Req_wdata, bus.Req_be};
        accept = bus.Req_valid && (state_q == ST_IDLE);
        req_d  = accept ? live : req_q;
        // With no wait states the RAM is accessed on the accept edge itself.
        src     = (state_q == ST_IDLE) ? live : req_q;
        src_err = addr_err(src.addr, BASE_ADDR, SPAN);
        off     = src.addr - BASE_ADDR;
        idx     = IDX_W'(off >> ALIGN_BITS);

        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdok_d     = rdok_q;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) enter_resp = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (bus.Resp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    rdok_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ram_en = enter_resp && !src_err;
        if (enter_resp) begin
            state_d = ST_RESP;
            err_d   = src_err;
            rdok_d  = !src_err && !src.we;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdok_q  <= rdok_d;
        end
    end

    always_ff @(posedge Clk) begin
        req_q <= req_d;
    end

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (Clk),
        .en    (ram_en),
        .we    (src.we),
        .be    (src.be),
        .idx   (idx),
        .wdata (src.wdata),
        .rdata (ram_rdata)
    );

    // RAM output only changes on a load entering RESP, so gating it keeps it stable and zero otherwise.
    assign bus.Req_ready  = (state_q == ST_IDLE);
    assign bus.Resp_valid = (state_q == ST_RESP);
    assign bus.Resp_err   = err_q;
    assign bus.Resp_rdata = rdok_q ? ram_rdata : '0;

endmodule
